sym_serializer: RTL



---
 rtl/sym_serializer.sv | 63 ++++++
 1 files changed

// File: rtl/sym_serializer.sv
// Word-to-symbol serializer: accepts WORDW-bit words over valid/ready and emits
// them MSB-first as a gap-free stream of 2-bit symbols, with a one-word pending slot.
module sym_serializer #(
    parameter int          WORDW    = 8,
    parameter logic [1:0]  IDLE_SYM = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WORDW-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [1:0]       sym,
    output logic             sym_valid,
    output logic             sym_last
);

    localparam int N  = WORDW / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [WORDW-1:0] sh;
    logic [WORDW-1:0] pend;
    logic             pend_full;
    logic [CW-1:0]    cnt;

    // The pending slot may accept at the same edge it hands its word to the shifter.
    assign word_ready = !reset && (!pend_full || cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            pend_full <= 1'b0;
            sym       <= IDLE_SYM;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
        end else begin
            if (cnt != '0) begin
                sym       <= sh[WORDW-1 -: 2];
                sh        <= sh << 2;
                cnt       <= cnt - CW'(1);
                sym_valid <= 1'b1;
                sym_last  <= (cnt == CW'(1));
            end else if (pend_full) begin
                sym       <= pend[WORDW-1 -: 2];
                sh        <= pend << 2;
                cnt       <= CW'(N - 1);
                pend_full <= 1'b0;
                sym_valid <= 1'b1;
                sym_last  <= (N == 1);
            end else begin
                sym       <= IDLE_SYM;
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
            end

            // Placed after the load so a same-edge accept keeps the slot full.
            if (word_valid && word_ready) begin
                pend      <= word_in;
                pend_full <= 1'b1;
            end
        end
    end

endmodule
